// File: rtl/paddle_collision.sv
// Ball-to-paddle contact detector with a lockout FSM that emits one collision pulse per contact.
// Optional rally counter is built when PADDLE_RALLY_COUNT_EN is defined.
module paddle_collision #(
    parameter int unsigned LEFT_FACE_X  = 20,
    parameter int unsigned RIGHT_FACE_X = 615,
    parameter int unsigned ZONE_W       = 6,
    parameter int unsigned PADDLE_H     = 60,
    parameter int unsigned LOCKOUT_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       x_vel,
    input  logic       game_over,
    input  logic [9:0] left_paddle_y,
    input  logic [9:0] right_paddle_y,
    output logic       collision,
    output logic       hit_side,
    output logic [7:0] rally_count
);

    localparam logic [10:0] LFace   = 11'(LEFT_FACE_X);
    localparam logic [10:0] RFace   = 11'(RIGHT_FACE_X);
    localparam logic [10:0] ZoneW   = 11'(ZONE_W);
    localparam logic [10:0] PaddleH = 11'(PADDLE_H);

    localparam int unsigned     CntW    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {StArmed, StHit, StLockout, StClear} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;

    logic [10:0] x_ext, y_ext, lpy_ext, rpy_ext;
    logic        left_x, right_x, left_y, right_y;
    logic        left_hit, right_hit, in_zone;

    // 11-bit arithmetic keeps paddle_y + PADDLE_H from wrapping
    assign x_ext   = {1'b0, x_pos};
    assign y_ext   = {1'b0, y_pos};
    assign lpy_ext = {1'b0, left_paddle_y};
    assign rpy_ext = {1'b0, right_paddle_y};

    assign left_x  = (x_ext + ZoneW > LFace) && (x_ext <= LFace);
    assign right_x = (x_ext >= RFace) && (x_ext < RFace + ZoneW);
    assign left_y  = (y_ext >= lpy_ext) && (y_ext < lpy_ext + PaddleH);
    assign right_y = (y_ext >= rpy_ext) && (y_ext < rpy_ext + PaddleH);

    assign left_hit  = !x_vel && left_x && left_y;
    assign right_hit = x_vel && right_x && right_y;
    assign in_zone   = (left_x && left_y) || (right_x && right_y);

    // The counter is loaded on entry to StHit so the pulse cycle counts toward the lockout,
    // placing the earliest re-arm sample at pulse + LOCKOUT_CYC + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StArmed;
            cnt_q     <= '0;
            collision <= 1'b0;
            hit_side  <= 1'b0;
        end else if (game_over) begin
            state_q   <= StArmed;
            cnt_q     <= '0;
            collision <= 1'b0;
        end else begin
            collision <= 1'b0;
            case (state_q)
                StArmed: begin
                    if (left_hit || right_hit) begin
                        state_q   <= StHit;
                        collision <= 1'b1;
                        hit_side  <= ~left_hit;
                        cnt_q     <= CntLoad;
                    end
                end
                StHit: begin
                    if (cnt_q == '0) begin
                        state_q <= StClear;
                    end else begin
                        cnt_q   <= cnt_q - CntW'(1);
                        state_q <= StLockout;
                    end
                end
                StLockout: begin
                    if (cnt_q == '0) begin
                        state_q <= StClear;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StClear: begin
                    if (!in_zone) begin
                        state_q <= StArmed;
                    end
                end
                default: state_q <= StArmed;
            endcase
        end
    end

`ifdef PADDLE_RALLY_COUNT_EN
    logic [7:0] rally_q;

    always_ff @(posedge clk) begin
        if (rst || game_over) begin
            rally_q <= 8'd0;
        end else if (state_q == StArmed && (left_hit || right_hit) && rally_q != 8'hFF) begin
            rally_q <= rally_q + 8'd1;
        end
    end

    assign rally_count = rally_q;
`else
    assign rally_count = 8'd0;
`endif

endmodule

// File: doc/paddle_collision.md
# paddle_collision

Detects ball-to-paddle contact for Pong and drives the single-cycle `collision` pulse consumed by the ball unit. It samples ball position, horizontal direction and both paddle positions every clock. A lockout state machine keeps one contact from producing repeated pulses while the ball is still inside the paddle zone. It sits between the paddle units and the ball unit in the game core.

## Interface
Parameters:
- `LEFT_FACE_X`, 20: x coordinate of the left paddle's inner face.
- `RIGHT_FACE_X`, 615: x coordinate of the right paddle's inner face.
- `ZONE_W`, 6: depth of each hit zone in pixels, measured behind the face.
- `PADDLE_H`, 60: paddle height in pixels.
- `LOCKOUT_CYC`, 16: cycles of forced lockout after a pulse (≥1).

Ports:
- One clock; reset is synchronous and active-high, named `clk` and `rst`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `x_pos`  in  10  ball x.
- `y_pos`  in  10  ball y.
- `x_vel`  in  1  ball direction: 1 = moving right, 0 = moving left.
- `game_over`  in  1  round ended; suppresses detection.
- `left_paddle_y`  in  10  top y of left paddle.
- `right_paddle_y`  in  10  top y of right paddle.
- `collision`  out  1  registered one-cycle hit pulse.
- `hit_side`  out  1  0 = left, 1 = right; updated with each pulse, held otherwise.
- `rally_count`  out  8  paddle hits since reset or game_over.

## Operation
- Zone tests use 11-bit arithmetic, so `paddle_y + PADDLE_H` cannot wrap.
- Left hit:
  - `x_vel==0`;
  - `LEFT_FACE_X-ZONE_W < x_pos <= LEFT_FACE_X`;
  - `left_paddle_y <= y_pos <= left_paddle_y+PADDLE_H-1`.
- Right hit:
  - `x_vel==1`;
  - `RIGHT_FACE_X <= x_pos < RIGHT_FACE_X+ZONE_W`;
  - same y test using `right_paddle_y`.
- `in_zone` is the same x/y test for either side, ignoring `x_vel`.
- State machine:
  - ARMED: left or right hit → HIT; if both hit, left wins.
  - HIT: `collision=1` for exactly this cycle; loads the lockout counter with `LOCKOUT_CYC-1`; → LOCKOUT.
  - LOCKOUT: counter decrements each cycle; at 0 → CLEAR.
  - CLEAR: stays while `in_zone`; → ARMED on the first cycle `in_zone` is 0.
- `game_over` high in any state:
  - next state is ARMED;
  - `collision` is 0 next cycle;
  - counter is cleared;
  - `rally_count` is cleared.
- `rst` has priority over everything and has the same effect as `game_over`; it also sets `hit_side=0`.
- Reset values:
  - `collision=0`, `hit_side=0`, `rally_count=0`;
  - state ARMED, counter 0.

## Timing
- Latency: inputs sampled at edge N satisfying a hit in ARMED → `collision` high during cycle N+1 only. `hit_side` is valid in the same cycle.
- After the pulse at N+1:
  - earliest possible next pulse is cycle N+1+`LOCKOUT_CYC`+2, reached only if the ball left the zone (CLEAR exits to ARMED, then one sample edge);
  - never earlier, even if the ball re-enters immediately.
- `game_over` or `rst` mid-pulse: a pulse already asserted completes its single cycle; no further pulse follows.
- `game_over` held high: ARMED is held and no pulses are emitted. Detection resumes on the first sample edge after it falls.
- A paddle moving during LOCKOUT or CLEAR has no effect until ARMED.

## Configuration
- `PADDLE_RALLY_COUNT_EN` defined:
  - `rally_count` increments on each HIT entry;
  - saturates at 255;
  - clears on `rst` or `game_over`.
- Not defined: the counter is not built and `rally_count` is tied to 8'd0.

## Test plan
- Left hit: `rst`, then `x_pos`=18, `y_pos`=100, `left_paddle_y`=80, `x_vel`=0 → `collision`=1 for exactly one cycle, next cycle after sampling; `hit_side`=0; `rally_count`=1 with macro on.
- Wrong direction: same position with `x_vel`=1 → no pulse. Right side `x_pos`=617, `x_vel`=1, `y_pos` in range → pulse with `hit_side`=1.
- Y boundary: `right_paddle_y`=400, `y_pos`=459 → pulse. `y_pos`=460 → none. `right_paddle_y`=1000 with `y_pos`=1020: no wrap, pulse.
- Lockout: hold a valid hit for 40 cycles → one pulse only. Move the ball out, then back at pulse+20 → second pulse no earlier than pulse+`LOCKOUT_CYC`+2 (pulse+18).
- Interrupts: assert `game_over` during LOCKOUT → ARMED next cycle, `rally_count`=0, no pulse while `game_over`=1. Assert `rst` in the HIT cycle → all outputs 0 next cycle.
- Saturation (macro on): 300 separated hits → `rally_count`=255. Macro off → `rally_count` stays 0 throughout.
